// File: rtl/counter_pkg.sv
// Shared encodings for the up/down counter slice: count direction and
// bound-handling mode, plus a helper that maps the integer SATURATE
// parameter onto the mode enum.
package counter_pkg;

    typedef enum logic {
        DOWN = 1'b0,
        UP   = 1'b1
    } dir_e;

    typedef enum logic {
        WRAP = 1'b0,
        SAT  = 1'b1
    } mode_e;

    // Any nonzero SATURATE selects hold-at-bounds behaviour.
    function automatic mode_e mode_of(input int saturate);
        return (saturate != 0) ? SAT : WRAP;
    endfunction

endpackage

// File: rtl/updown_counter_prescaler.sv
// Step prescaler: counts enabled cycles and raises a combinational strobe on
// the enabled cycle that completes a PRESCALE-long group. sync_clr restarts
// the group and suppresses the strobe on that edge.
module step_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    input  logic sync_clr,
    output logic strobe
);

    localparam int              CW   = $clog2(PRESCALE + 1);
    localparam logic [CW-1:0]   LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    // Strobe on the edge that finishes a group, so the count steps on that same edge.
    assign strobe = en && !sync_clr && (cnt == LAST);

    // Group position: cleared by reset/sync_clr, frozen while en is low.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rstn) begin
            cnt <= '0;
        end else if (sync_clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= strobe ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/updown_counter.sv
// Up/down counter with programmable upper bound, wrap or saturate at the
// bounds, enable prescaler, synchronous clear/load, a one-cycle terminal
// count pulse and a sticky boundary-crossing flag.
module updown_counter
    import counter_pkg::*;
#(
    parameter int              WIDTH    = 8,
    parameter longint unsigned MAX      = (64'd1 << WIDTH) - 64'd1,
    parameter int              SATURATE = 0,
    parameter int              PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             up_down,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf
);

    // Illegal parameter sets stop elaboration outright.
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "updown_counter: WIDTH=%0d outside 1..32", WIDTH);
    end
    if (MAX < 64'd1 || MAX > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
        $fatal(1, "updown_counter: MAX=%0d outside 1..2**WIDTH-1", MAX);
    end
    if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
        $fatal(1, "updown_counter: PRESCALE=%0d outside 1..65535", PRESCALE);
    end

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam mode_e            MODE  = mode_of(SATURATE);

    dir_e             dir;
    logic             step;
    logic             boundary;
    logic [WIDTH-1:0] out_next;

    assign dir = dir_e'(up_down);

    // clr or load restarts the prescale group; both also block its advance.
    step_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .sync_clr (clr | load),
        .strobe   (step)
    );

    // Next count by priority clr > load > step > hold, flagging boundary events.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        out_next = out;
        boundary = 1'b0;
        if (clr) begin
            out_next = '0;
        end else if (load) begin
            out_next = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (step) begin
            if (dir == UP) begin
                if (out >= MAX_V) begin
                    boundary = 1'b1;
                    out_next = (MODE == SAT) ? MAX_V : '0;
                end else begin
                    out_next = out + 1'b1;
                end
            end else begin
                if (out == '0) begin
                    boundary = 1'b1;
                    out_next = (MODE == SAT) ? '0 : MAX_V;
                end else begin
                    out_next = out - 1'b1;
                end
            end
        end
    end

    // Registered count and terminal-count pulse (high the cycle after a boundary event).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out <= '0;
            tc  <= 1'b0;
        end else begin
            out <= out_next;
            tc  <= boundary;
        end
    end

    // Sticky boundary flag; a set on the same edge as ovf_clr wins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf <= 1'b0;
        end else if (boundary) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter. Three instances share all inputs:
//   dut_a : WIDTH=8, MAX=255, wrap, PRESCALE=1
//   dut_s : WIDTH=8, MAX=9,   saturate, PRESCALE=1
//   dut_p : WIDTH=8, MAX=255, wrap, PRESCALE=3
// Inputs change 1 time unit after the rising edge; outputs are read there too.
module tb_updown_counter;

    logic       clk = 1'b0;
    logic       rstn;
    logic       en;
    logic       up_down;
    logic       clr;
    logic       load;
    logic [7:0] load_val;
    logic       ovf_clr;

    logic [7:0] a_out, s_out, p_out;
    logic       a_tc, s_tc, p_tc;
    logic       a_ovf, s_ovf, p_ovf;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    updown_counter dut_a (
        .clk(clk), .rstn(rstn), .en(en), .up_down(up_down), .clr(clr),
        .load(load), .load_val(load_val), .ovf_clr(ovf_clr),
        .out(a_out), .tc(a_tc), .ovf(a_ovf)
    );

    updown_counter #(.WIDTH(8), .MAX(9), .SATURATE(1), .PRESCALE(1)) dut_s (
        .clk(clk), .rstn(rstn), .en(en), .up_down(up_down), .clr(clr),
        .load(load), .load_val(load_val), .ovf_clr(ovf_clr),
        .out(s_out), .tc(s_tc), .ovf(s_ovf)
    );

    updown_counter #(.WIDTH(8), .MAX(255), .SATURATE(0), .PRESCALE(3)) dut_p (
        .clk(clk), .rstn(rstn), .en(en), .up_down(up_down), .clr(clr),
        .load(load), .load_val(load_val), .ovf_clr(ovf_clr),
        .out(p_out), .tc(p_tc), .ovf(p_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en = 1'b0; up_down = 1'b1; clr = 1'b0; load = 1'b0;
        load_val = 8'd0; ovf_clr = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        idle_inputs();
        #12;
        compared++;
        if ({a_out, a_tc, a_ovf} !== {8'd0, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_a: got out=%0d tc=%b ovf=%b, want out=0 tc=0 ovf=0", a_out, a_tc, a_ovf);
        end
        compared++;
        if ({s_out, s_tc, s_ovf} !== {8'd0, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_s: got out=%0d tc=%b ovf=%b, want out=0 tc=0 ovf=0", s_out, s_tc, s_ovf);
        end
        compared++;
        if ({p_out, p_tc, p_ovf} !== {8'd0, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_p: got out=%0d tc=%b ovf=%b, want out=0 tc=0 ovf=0", p_out, p_tc, p_ovf);
        end
        @(negedge clk);
        rstn = 1'b1;
        tick();
    endtask

    // 257 enabled up-steps from 0 on the 8-bit wrapping counter.
    task automatic test_wrap_count();
        logic [7:0] exp_out;
        logic       exp_tc, exp_ovf;
        en = 1'b1; up_down = 1'b1;
        for (int i = 1; i <= 257; i++) begin
            tick();
            exp_out = 8'(i % 256);
            exp_tc  = (i == 256);
            exp_ovf = (i >= 256);
            compared++;
            if ({a_out, a_tc, a_ovf} !== {exp_out, exp_tc, exp_ovf}) begin
                mismatched++;
                $display("FAIL wrap_step%0d: got out=%0d tc=%b ovf=%b, want out=%0d tc=%b ovf=%b",
                         i, a_out, a_tc, a_ovf, exp_out, exp_tc, exp_ovf);
            end
        end
        en = 1'b0;
        tick();
        compared++;
        if ({a_out, a_tc, a_ovf} !== {8'd1, 1'b0, 1'b1}) begin
            mismatched++;
            $display("FAIL wrap_freeze: got out=%0d tc=%b ovf=%b, want out=1 tc=0 ovf=1", a_out, a_tc, a_ovf);
        end
    endtask

    // MAX=9 saturating, load 2 then four down steps: 1,0,0,0.
    task automatic test_saturate_down();
        logic [7:0] exp_out [4] = '{8'd1, 8'd0, 8'd0, 8'd0};
        logic       exp_tc  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic       exp_ovf [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        en = 1'b0; up_down = 1'b0;
        load = 1'b1; load_val = 8'd2; ovf_clr = 1'b1;
        tick();
        load = 1'b0; ovf_clr = 1'b0;
        compared++;
        if ({s_out, s_tc, s_ovf} !== {8'd2, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL sat_load: got out=%0d tc=%b ovf=%b, want out=2 tc=0 ovf=0", s_out, s_tc, s_ovf);
        end
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            compared++;
            if ({s_out, s_tc, s_ovf} !== {exp_out[i], exp_tc[i], exp_ovf[i]}) begin
                mismatched++;
                $display("FAIL sat_step%0d: got out=%0d tc=%b ovf=%b, want out=%0d tc=%b ovf=%b",
                         i, s_out, s_tc, s_ovf, exp_out[i], exp_tc[i], exp_ovf[i]);
            end
        end
        en = 1'b0;
        tick();
        compared++;
        if ({s_out, s_tc, s_ovf} !== {8'd0, 1'b0, 1'b1}) begin
            mismatched++;
            $display("FAIL sat_en_off: got out=%0d tc=%b ovf=%b, want out=0 tc=0 ovf=1", s_out, s_tc, s_ovf);
        end
    endtask

    // PRESCALE=3: en 1,1,0,1,1,1,1 then a mid-group direction change.
    task automatic test_prescale();
        logic       en_pat  [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [7:0] exp_out [7] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2};
        logic       dir_pat [3] = '{1'b1, 1'b0, 1'b0};
        logic [7:0] exp_dir [3] = '{8'd2, 8'd2, 8'd1};
        clr = 1'b1;
        tick();
        clr = 1'b0; up_down = 1'b1;
        for (int i = 0; i < 7; i++) begin
            en = en_pat[i];
            tick();
            compared++;
            if (p_out !== exp_out[i]) begin
                mismatched++;
                $display("FAIL prescale_cyc%0d: got out=%0d, want out=%0d", i, p_out, exp_out[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            en = 1'b1; up_down = dir_pat[i];
            tick();
            compared++;
            if (p_out !== exp_dir[i]) begin
                mismatched++;
                $display("FAIL prescale_dir%0d: got out=%0d, want out=%0d", i, p_out, exp_dir[i]);
            end
        end
        en = 1'b0;
    endtask

    // clr beats load; load clamps to MAX; clr leaves ovf alone.
    task automatic test_priority();
        load = 1'b1; load_val = 8'd3;
        tick();
        clr = 1'b1; load = 1'b1; load_val = 8'd5;
        tick();
        clr = 1'b0;
        compared++;
        if ({s_out, s_tc, s_ovf, a_out} !== {8'd0, 1'b0, 1'b1, 8'd0}) begin
            mismatched++;
            $display("FAIL clr_over_load: got s_out=%0d s_tc=%b s_ovf=%b a_out=%0d, want 0 0 1 0",
                     s_out, s_tc, s_ovf, a_out);
        end
        load = 1'b1; load_val = 8'd200;
        tick();
        load = 1'b0;
        compared++;
        if ({s_out, a_out} !== {8'd9, 8'd200}) begin
            mismatched++;
            $display("FAIL load_clamp: got s_out=%0d a_out=%0d, want s_out=9 a_out=200", s_out, a_out);
        end
    endtask

    // ovf set and ovf_clr on the same edge keeps ovf; ovf_clr alone clears it.
    task automatic test_ovf_clr();
        load = 1'b1; load_val = 8'd255; ovf_clr = 1'b1;
        tick();
        load = 1'b0;
        compared++;
        if ({a_out, a_ovf} !== {8'd255, 1'b0}) begin
            mismatched++;
            $display("FAIL ovf_pre: got out=%0d ovf=%b, want out=255 ovf=0", a_out, a_ovf);
        end
        en = 1'b1; up_down = 1'b1; ovf_clr = 1'b1;
        tick();
        compared++;
        if ({a_out, a_tc, a_ovf} !== {8'd0, 1'b1, 1'b1}) begin
            mismatched++;
            $display("FAIL ovf_set_wins: got out=%0d tc=%b ovf=%b, want out=0 tc=1 ovf=1", a_out, a_tc, a_ovf);
        end
        en = 1'b0;
        tick();
        ovf_clr = 1'b0;
        compared++;
        if ({a_out, a_tc, a_ovf} !== {8'd0, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL ovf_cleared: got out=%0d tc=%b ovf=%b, want out=0 tc=0 ovf=0", a_out, a_tc, a_ovf);
        end
    endtask

    // Async reset mid-cycle with out=7 ovf=1; prescaler progress is discarded.
    task automatic test_async_reset();
        logic [7:0] exp_a [3] = '{8'd1, 8'd2, 8'd3};
        logic [7:0] exp_p [3] = '{8'd0, 8'd0, 8'd1};
        clr = 1'b1;
        tick();
        clr = 1'b0;
        load = 1'b1; load_val = 8'd255;
        tick();
        load = 1'b0; en = 1'b1; up_down = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        en = 1'b0;
        compared++;
        if ({a_out, a_ovf, p_out} !== {8'd7, 1'b1, 8'd1}) begin
            mismatched++;
            $display("FAIL areset_pre: got a_out=%0d a_ovf=%b p_out=%0d, want 7 1 1", a_out, a_ovf, p_out);
        end
        #2 rstn = 1'b0;
        #1;
        compared++;
        if ({a_out, a_tc, a_ovf, p_out} !== {8'd0, 1'b0, 1'b0, 8'd0}) begin
            mismatched++;
            $display("FAIL areset_now: got a_out=%0d a_tc=%b a_ovf=%b p_out=%0d, want 0 0 0 0",
                     a_out, a_tc, a_ovf, p_out);
        end
        en = 1'b1;
        tick();
        compared++;
        if (a_out !== 8'd0) begin
            mismatched++;
            $display("FAIL areset_hold: got out=%0d, want out=0", a_out);
        end
        #3 rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            compared++;
            if ({a_out, p_out} !== {exp_a[i], exp_p[i]}) begin
                mismatched++;
                $display("FAIL areset_resume%0d: got a_out=%0d p_out=%0d, want a_out=%0d p_out=%0d",
                         i, a_out, p_out, exp_a[i], exp_p[i]);
            end
        end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap_count();
        test_saturate_down();
        test_prescale();
        test_priority();
        test_ovf_clr();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
